// File: rtl/prog_loader.sv
// Program-memory loader: parses SYNC/ADDR/LEN/DATA/CSUM frames from a byte stream,
// writes payload into program memory and holds the CPU until a checksum-good frame lands.
//   state  | meaning
//   HUNT   | dropping bytes until SYNC_BYTE
//   ADDR   | expecting start address
//   LEN    | expecting payload length (0 = 256)
//   DATA   | writing payload bytes
//   CSUM   | expecting checksum byte
//   FINISH | one-cycle pause before hunting again
module prog_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'h55,
  parameter int         TIMEOUT   = 1000,
  parameter int         TMO_W     = 16
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] inData,
  input  logic       inValid,
  output logic       inReady,
  output logic [7:0] memWrAddr,
  output logic [7:0] memWrData,
  output logic       memWrStrobe,
  output logic       cpuHold,
  output logic       loadDone,
  output logic       loadError
);

  typedef enum logic [2:0] {HUNT, ADDR, LEN, DATA, CSUM, FINISH} state_t;

  state_t           state, nextState;
  logic [7:0]       wrPtr;
  logic [7:0]       sum;
  logic [8:0]       remaining;
  logic [TMO_W-1:0] tmoCnt;
  logic             accept;
  logic             inFrame;
  logic             tmoHit;
  logic [7:0]       sumNext;

  assign accept  = inValid & inReady;
  assign inFrame = (state == ADDR) || (state == LEN) || (state == DATA) || (state == CSUM);
  // A byte arriving on the terminal idle cycle beats the abort.
  assign tmoHit  = inFrame && !accept && (tmoCnt == TMO_W'(TIMEOUT - 1));
  assign sumNext = sum + inData;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= HUNT;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      HUNT:    if (accept && inData == SYNC_BYTE) nextState = ADDR;
      ADDR:    if (accept) nextState = LEN;
      LEN:     if (accept) nextState = DATA;
      DATA:    if (accept && remaining == 9'd1) nextState = CSUM;
      CSUM:    if (accept) nextState = FINISH;
      FINISH:  nextState = HUNT;
      default: nextState = HUNT;
    endcase
    if (tmoHit) nextState = HUNT;
  end

  always_comb begin
    inReady = 1'b0;
    if (resetN && state != FINISH) inReady = 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wrPtr       <= '0;
      sum         <= '0;
      remaining   <= '0;
      tmoCnt      <= '0;
      memWrAddr   <= '0;
      memWrData   <= '0;
      memWrStrobe <= 1'b0;
      cpuHold     <= 1'b1;
      loadDone    <= 1'b0;
      loadError   <= 1'b0;
    end else begin
      memWrStrobe <= 1'b0;
      loadDone    <= 1'b0;
      loadError   <= 1'b0;
      if (!inFrame || accept) tmoCnt <= '0;
      else                    tmoCnt <= tmoCnt + 1'b1;
      case (state)
        HUNT: if (accept && inData == SYNC_BYTE) cpuHold <= 1'b1;
        ADDR: if (accept) begin
          wrPtr <= inData;
          sum   <= inData;
        end
        LEN: if (accept) begin
          remaining <= (inData == 8'd0) ? 9'd256 : {1'b0, inData};
          sum       <= sumNext;
        end
        DATA: if (accept) begin
          sum         <= sumNext;
          memWrAddr   <= wrPtr;
          memWrData   <= inData;
          memWrStrobe <= 1'b1;
          wrPtr       <= wrPtr + 8'd1;
          remaining   <= remaining - 9'd1;
        end
        CSUM: if (accept) begin
          if (sumNext == 8'd0) begin
            loadDone <= 1'b1;
            cpuHold  <= 1'b0;
          end else begin
            loadError <= 1'b1;
          end
        end
        default: ;
      endcase
      if (tmoHit) loadError <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed and random frames checked against a memory-image model
// built from the frame checksum rule; also timeout, boundary stall and mid-frame reset.
module tb_prog_loader;
  localparam logic [7:0] SYNC = 8'h55;
  localparam int         TMO  = 40;

  logic       clk = 1'b0;
  logic       resetN;
  logic [7:0] inData;
  logic       inValid;
  logic       inReady;
  logic [7:0] memWrAddr, memWrData;
  logic       memWrStrobe, cpuHold, loadDone, loadError;

  prog_loader #(.SYNC_BYTE(SYNC), .TIMEOUT(TMO), .TMO_W(16)) dut (
    .clk(clk), .resetN(resetN), .inData(inData), .inValid(inValid), .inReady(inReady),
    .memWrAddr(memWrAddr), .memWrData(memWrData), .memWrStrobe(memWrStrobe),
    .cpuHold(cpuHold), .loadDone(loadDone), .loadError(loadError)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;
  int wrCnt = 0, doneCnt = 0, errCnt = 0;
  int expWr = 0, expDone = 0, expErr = 0;
  logic [7:0] tbMem [256];
  logic [7:0] expMem [256];
  logic [7:0] frameData [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (memWrStrobe === 1'b1) begin
      tbMem[memWrAddr] = memWrData;
      wrCnt++;
    end
    if (loadDone === 1'b1)  doneCnt++;
    if (loadError === 1'b1) errCnt++;
  end

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    while (!inReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!inReady) chk("ready_wait", 32'(inReady), 32'd1);
    inData  = b;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic checkTotals(input string tag);
    int diff = 0;
    for (int k = 0; k < 256; k++) if (tbMem[k] !== expMem[k]) diff++;
    chk({tag, "_memdiff"}, 32'(diff), 32'd0);
    chk({tag, "_wrcnt"}, 32'(wrCnt), 32'(expWr));
    chk({tag, "_donecnt"}, 32'(doneCnt), 32'(expDone));
    chk({tag, "_errcnt"}, 32'(errCnt), 32'(expErr));
  endtask

  task automatic sendFrame(input string tag, input logic [7:0] addr, input int len,
                           input logic [7:0] badXor, input int stallIdx, input int stallCyc);
    logic [7:0] lenB, csum, a;
    int total;
    bit good;
    lenB  = len[7:0];
    total = int'(addr) + int'(lenB);
    for (int i = 0; i < len; i++) total += int'(frameData[i]);
    csum  = 8'((256 - (total % 256)) % 256) ^ badXor;
    good  = ((total + int'(csum)) % 256) == 0;
    sendByte(SYNC);
    chk({tag, "_hold_sync"}, 32'(cpuHold), 32'd1);
    sendByte(addr);
    sendByte(lenB);
    for (int i = 0; i < len; i++) begin
      if (i == stallIdx) repeat (stallCyc) @(negedge clk);
      sendByte(frameData[i]);
      a = 8'((int'(addr) + i) % 256);
      expMem[a] = frameData[i];
      expWr++;
      chk({tag, "_wr"}, {15'd0, memWrStrobe, memWrAddr, memWrData}, {15'd0, 1'b1, a, frameData[i]});
    end
    sendByte(csum);
    if (good) expDone++; else expErr++;
    chk({tag, "_done"}, 32'(loadDone), 32'(good));
    chk({tag, "_err"}, 32'(loadError), 32'(!good));
    chk({tag, "_hold"}, 32'(cpuHold), 32'(!good));
    chk({tag, "_finish_rdy"}, 32'(inReady), 32'd0);
    @(negedge clk);
    chk({tag, "_pulse_end"}, {30'd0, loadDone, loadError}, 32'd0);
    chk({tag, "_hunt_rdy"}, 32'(inReady), 32'd1);
    checkTotals(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, len, stIdx, stCyc;
    logic [7:0] g, bad;
    for (int k = 0; k < 256; k++) begin
      tbMem[k]  = 8'h00;
      expMem[k] = 8'h00;
    end
    resetN = 1'b0; inValid = 1'b0; inData = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(inReady), 32'd0);
    chk("rst_outs", {28'd0, memWrStrobe, cpuHold, loadDone, loadError}, {28'd0, 4'b0100});
    resetN = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready", 32'(inReady), 32'd1);

    frameData[0] = 8'hAA; frameData[1] = 8'hBB; frameData[2] = 8'hCC;
    sendFrame("good10", 8'h10, 3, 8'h00, -1, 0);
    sendFrame("badcs", 8'h10, 3, 8'h01, -1, 0);
    frameData[0] = 8'h01; frameData[1] = 8'h02; frameData[2] = 8'h03;
    sendFrame("wrap", 8'hFE, 3, 8'h00, -1, 0);
    frameData[0] = SYNC; frameData[1] = SYNC;
    sendFrame("syncdata", 8'h30, 2, 8'h00, -1, 0);
    for (int i = 0; i < 256; i++) frameData[i] = 8'(i);
    sendFrame("len256", 8'h00, 256, 8'h00, -1, 0);

    // Timeout abort after TMO idle cycles inside a frame.
    sendByte(SYNC); sendByte(8'h20); sendByte(8'h02); sendByte(8'h01);
    expMem[8'h20] = 8'h01; expWr++;
    n = 0;
    for (int i = 1; i <= 3 * TMO; i++) begin
      @(negedge clk);
      if (loadError) begin n = i; break; end
    end
    chk("tmo_cycles", 32'(n), 32'(TMO));
    expErr++;
    chk("tmo_hold", 32'(cpuHold), 32'd1);
    chk("tmo_done", 32'(loadDone), 32'd0);
    @(negedge clk);
    chk("tmo_hunt_rdy", 32'(inReady), 32'd1);
    checkTotals("tmo");
    frameData[0] = 8'h5A; frameData[1] = 8'hA5;
    sendFrame("after_tmo", 8'h20, 2, 8'h00, -1, 0);

    // Byte arriving on the last allowed idle cycle must not abort.
    frameData[0] = 8'h11; frameData[1] = 8'h22; frameData[2] = 8'h33;
    sendFrame("edge_stall", 8'h60, 3, 8'h00, 1, TMO - 1);

    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 1) == 1) begin
        g = 8'($urandom_range(0, 255));
        if (g == SYNC) g = 8'h56;
        sendByte(g);
      end
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) frameData[i] = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      stIdx = $urandom_range(0, len - 1);
      stCyc = $urandom_range(0, TMO - 1);
      sendFrame("rand", 8'($urandom_range(0, 255)), len, bad, stIdx, stCyc);
    end

    // Garbage with sparse valid, then reset in the middle of DATA.
    frameData[0] = 8'h77;
    sendFrame("pre_rst", 8'h80, 1, 8'h00, -1, 0);
    sendByte(8'h12); @(negedge clk); sendByte(8'h34); @(negedge clk);
    chk("garbage_hold", 32'(cpuHold), 32'd0);
    checkTotals("garbage");
    sendByte(SYNC); sendByte(8'h40); sendByte(8'h05); sendByte(8'hD0); sendByte(8'hD1);
    expMem[8'h40] = 8'hD0; expMem[8'h41] = 8'hD1; expWr += 2;
    #2 resetN = 1'b0;
    inValid = 1'b1; inData = 8'hEE;
    @(negedge clk);
    chk("midrst_ready", 32'(inReady), 32'd0);
    chk("midrst_outs", {29'd0, memWrStrobe, cpuHold, loadDone}, {29'd0, 3'b010});
    @(negedge clk);
    chk("midrst_strobe", 32'(memWrStrobe), 32'd0);
    inValid = 1'b0;
    #2 resetN = 1'b1;
    @(negedge clk);
    chk("midrst_rel_hold", 32'(cpuHold), 32'd1);
    checkTotals("midrst");
    frameData[0] = 8'h9C; frameData[1] = 8'hC9; frameData[2] = 8'h00; frameData[3] = 8'hFF;
    sendFrame("after_rst", 8'h40, 4, 8'h00, -1, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
